vector_magnitude: RTL
=====================

VECTOR_MAGNITUDE -- requirements
Module: vector_magnitude

Interface
REQ-001 Parameter: NUM_BITS, default `BYTE_BITS (8), width of each signed component and of the result.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 clk_en  input  1  module enable; state advances only on clk edges with clk_en=1.
REQ-005 dx  input  NUM_BITS  signed X component, two's complement, sampled on accepted trigger.
REQ-006 dy  input  NUM_BITS  signed Y component, two's complement, sampled on accepted trigger.
REQ-007 trigger  input  1  starts a computation; accepted only when rdy=1 and clk_en=1.
REQ-008 mag_out  output  NUM_BITS  unsigned magnitude sqrt(dx^2+dy^2); valid only while done=1.
REQ-009 done  output  1  result valid; high from completion until the next accepted trigger.
REQ-010 rdy  output  1  ready for a new trigger; high in IDLE and DONE.

Function
REQ-011 The block SHALL implement the FSM states IDLE, MUL_X, MUL_Y, SQRT_REQ, SQRT_WAIT, ROUND, DONE.
REQ-012 Accepted trigger in IDLE or DONE SHALL latch |dx|, |dy| (NUM_BITS unsigned), clear the 2*NUM_BITS accumulator, drop done, and enter MUL_X.
REQ-013 |-(2^(NUM_BITS-1))| SHALL equal 2^(NUM_BITS-1) with no saturation.
REQ-014 MUL_X and MUL_Y SHALL each take exactly NUM_BITS clk_en cycles, one shift-add step per cycle, adding |dx|^2 then |dy|^2 into the accumulator.
REQ-015 Accumulator width SHALL be 2*NUM_BITS; the sum never overflows (max 2^(2*NUM_BITS-1)).
REQ-016 SQRT_REQ SHALL drive the internal integer-sqrt trigger for one clk_en cycle with the accumulator as operand, then move to SQRT_WAIT.
REQ-017 SQRT_WAIT SHALL hold until the sqrt block's done; its result is the floor root, truncated to NUM_BITS (never loses bits).
REQ-018 Without rounding (see Configuration), SQRT_WAIT SHALL go directly to DONE; ROUND is unreachable.
REQ-019 DONE SHALL drive done=1, rdy=1, and hold mag_out stable until the next accepted trigger.
REQ-020 Trigger outside IDLE/DONE SHALL be ignored with no effect on the current computation.
REQ-021 Trigger in DONE with clk_en=1 SHALL restart in the same cycle; done falls on that edge.
REQ-022 clk_en=0 SHALL freeze all state, including the sqrt sub-block (clk_en passed through).
REQ-023 Result SHALL be available within 4*NUM_BITS+8 clk_en cycles of trigger acceptance.
REQ-024 dx=dy=0 SHALL yield mag_out=0 through the normal state sequence.

Reset
REQ-025 reset low SHALL immediately force IDLE, mag_out=0, done=0, rdy=1, and clear operands and accumulator, including mid-computation.
REQ-026 The sqrt sub-block SHALL be reset from the same reset, with its polarity adapted.
REQ-027 The first trigger after reset is released SHALL be accepted normally.

Configuration
REQ-028 Macro VECTOR_MAGNITUDE_ROUND_EN defined: SQRT_WAIT SHALL enter ROUND; if accumulator - s^2 > s, then mag_out = s+1, else mag_out = s; ROUND takes one clk_en cycle.
REQ-029 Macro undefined: mag_out SHALL be the floor root, and no ROUND logic is synthesized.

Structure
REQ-030 The state enum type vector_magnitude_state_t SHALL live in the shared common package, next to the existing width constants.
REQ-031 A sub-module vector_magnitude_fsm SHALL hold state and transitions; the datapath SHALL reuse the existing integer-sqrt block (2*NUM_BITS width) unmodified.

Verification (NUM_BITS=8)
REQ-032 dx=3, dy=4, trigger -> done=1, mag_out=5 within 40 cycles; rdy=1.
REQ-033 dx=-128, dy=-128 -> mag_out=181 (sum 32768), with both round and floor builds.
REQ-034 dx=3, dy=2 -> mag_out=3 (floor build) / 4 (ROUND_EN build); dx=0, dy=0 -> 0.
REQ-035 Trigger pulses with new dx/dy during MUL_Y and SQRT_WAIT -> ignored; original result delivered; clk_en toggled 50% -> same result, latency doubled.
REQ-036 reset asserted during SQRT_WAIT -> outputs 0/0/1 immediately; the next trigger with dx=6, dy=8 -> 10.

Source files
------------

// File: rtl/vector_magnitude_pkg.sv
// Shared width constants and the vector_magnitude state type.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package vector_magnitude_pkg;

    localparam int BYTE_BITS = `BYTE_BITS;

    typedef enum logic [2:0] {
        IDLE,
        MUL_X,
        MUL_Y,
        SQRT_REQ,
        SQRT_WAIT,
        ROUND,
        DONE
    } vector_magnitude_state_t;

endpackage

// File: rtl/int_sqrt.sv
// Iterative integer square root: one result bit per enabled cycle, floor root.
// Active-high asynchronous reset; done pulses for one enabled cycle with root valid.
module int_sqrt #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic [WIDTH/2-1:0]   root,
    output logic                 done
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF) + 1;

    logic [WIDTH-1:0] rad_q;
    logic [HALF+1:0]  rem_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic [HALF+1:0]  rem_shift;
    logic [HALF+1:0]  trial;

    // Bring down the next two radicand bits and form the trial subtrahend 4*root+1.
    always_comb begin
        rem_shift = {rem_q[HALF-1:0], rad_q[WIDTH-1 -: 2]};
        trial     = {root, 2'b01};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rad_q   <= '0;
            rem_q   <= '0;
            root    <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done    <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            if (start) begin
                rad_q   <= radicand;
                rem_q   <= '0;
                root    <= '0;
                count_q <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                rad_q <= rad_q << 2;
                if (rem_shift >= trial) begin
                    rem_q <= rem_shift - trial;
                    root  <= {root[HALF-2:0], 1'b1};
                end else begin
                    rem_q <= rem_shift;
                    root  <= {root[HALF-2:0], 1'b0};
                end
                count_q <= count_q + 1'b1;
                if (count_q == CW'(HALF - 1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vector_magnitude_fsm.sv
// Control FSM for vector_magnitude: state register, bit counter and handshakes.
// Optional ROUND step enabled by VECTOR_MAGNITUDE_ROUND_EN.
module vector_magnitude_fsm
    import vector_magnitude_pkg::*;
#(
    parameter int NUM_BITS = BYTE_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          trigger,
    input  logic                          sqrt_done,
    output vector_magnitude_state_t       state,
    output logic [$clog2(NUM_BITS)-1:0]   bit_idx,
    output logic                          accept,
    output logic                          sqrt_start,
    output logic                          rdy,
    output logic                          done
);

    localparam int CNT_W = $clog2(NUM_BITS);

    vector_magnitude_state_t next_state;
    logic                    last_bit;

    assign last_bit = (bit_idx == CNT_W'(NUM_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_idx <= '0;
        end else if (clk_en) begin
            state <= next_state;
            if ((state == MUL_X || state == MUL_Y) && !last_bit) begin
                bit_idx <= bit_idx + 1'b1;
            end else begin
                bit_idx <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        rdy        = 1'b0;
        done       = 1'b0;
        sqrt_start = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                rdy    = 1'b1;
                done   = (state == DONE);
                accept = trigger && clk_en;
                if (trigger) begin
                    next_state = MUL_X;
                end
            end
            MUL_X: begin
                if (last_bit) begin
                    next_state = MUL_Y;
                end
            end
            MUL_Y: begin
                if (last_bit) begin
                    next_state = SQRT_REQ;
                end
            end
            SQRT_REQ: begin
                sqrt_start = 1'b1;
                next_state = SQRT_WAIT;
            end
            SQRT_WAIT: begin
                if (sqrt_done) begin
`ifdef VECTOR_MAGNITUDE_ROUND_EN
                    next_state = ROUND;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef VECTOR_MAGNITUDE_ROUND_EN
            ROUND: begin
                next_state = DONE;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/vector_magnitude.sv
// Vector magnitude sqrt(dx^2+dy^2) by shift-add squaring and an iterative root.
// Define VECTOR_MAGNITUDE_ROUND_EN to round to nearest instead of floor.
module vector_magnitude
    import vector_magnitude_pkg::*;
#(
    parameter int NUM_BITS = BYTE_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic signed [NUM_BITS-1:0] dx,
    input  logic signed [NUM_BITS-1:0] dy,
    input  logic                       trigger,
    output logic [NUM_BITS-1:0]        mag_out,
    output logic                       done,
    output logic                       rdy
);

    localparam int ACC_W = 2 * NUM_BITS;

    vector_magnitude_state_t           state;
    logic [$clog2(NUM_BITS)-1:0]       bit_idx;
    logic                              accept;
    logic                              sqrt_start;
    logic                              sqrt_done;
    logic                              sqrt_reset;
    logic [NUM_BITS-1:0]               root;
    logic [NUM_BITS-1:0]               abs_x;
    logic [NUM_BITS-1:0]               abs_y;
    logic [NUM_BITS-1:0]               dx_mag;
    logic [NUM_BITS-1:0]               dy_mag;
    logic [NUM_BITS-1:0]               operand;
    logic [ACC_W-1:0]                  acc;
    logic [ACC_W-1:0]                  term;

    // Two's complement negation of the most negative value yields 2^(NUM_BITS-1) unsigned.
    assign dx_mag     = dx[NUM_BITS-1] ? (~dx + 1'b1) : dx;
    assign dy_mag     = dy[NUM_BITS-1] ? (~dy + 1'b1) : dy;
    assign operand    = (state == MUL_X) ? abs_x : abs_y;
    assign term       = operand[bit_idx] ? (ACC_W'(operand) << bit_idx) : '0;
    assign sqrt_reset = ~reset;

`ifdef VECTOR_MAGNITUDE_ROUND_EN
    logic [ACC_W-1:0] floor_sq;
    logic             round_up;

    assign floor_sq = ACC_W'(mag_out) * ACC_W'(mag_out);
    assign round_up = (acc - floor_sq) > ACC_W'(mag_out);
`endif

    vector_magnitude_fsm #(
        .NUM_BITS (NUM_BITS)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .trigger    (trigger),
        .sqrt_done  (sqrt_done),
        .state      (state),
        .bit_idx    (bit_idx),
        .accept     (accept),
        .sqrt_start (sqrt_start),
        .rdy        (rdy),
        .done       (done)
    );

    int_sqrt #(
        .WIDTH (ACC_W)
    ) u_sqrt (
        .clk      (clk),
        .reset    (sqrt_reset),
        .clk_en   (clk_en),
        .start    (sqrt_start),
        .radicand (acc),
        .root     (root),
        .done     (sqrt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abs_x   <= '0;
            abs_y   <= '0;
            acc     <= '0;
            mag_out <= '0;
        end else if (clk_en) begin
            if (accept) begin
                abs_x   <= dx_mag;
                abs_y   <= dy_mag;
                acc     <= '0;
                mag_out <= '0;
            end else if (state == MUL_X || state == MUL_Y) begin
                acc <= acc + term;
            end else if (state == SQRT_WAIT && sqrt_done) begin
                mag_out <= root;
            end
`ifdef VECTOR_MAGNITUDE_ROUND_EN
            else if (state == ROUND && round_up) begin
                mag_out <= mag_out + 1'b1;
            end
`endif
        end
    end

endmodule
